// File: rtl/branch_hazard_unit.sv
// ID-stage beq hazard detection and resolution: stall sequencing, next-PC select and optional branch statistics.
// Statistic counters are built only when BRANCH_HAZARD_STATS_EN is defined; otherwise the count ports read 0.
module branch_hazard_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        ex_regwrite_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        mem_regwrite_i,
  input  logic        mem_memread_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        equal_i,
  input  logic [31:0] target_i,
  output logic        stall_o,
  output logic        bubble_o,
  output logic        pc_src_o,
  output logic [31:0] pc_target_o,
  output logic        flush_o,
  output logic [31:0] taken_cnt_o,
  output logic [31:0] nottaken_cnt_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL2  = 2'd1,
    STALL1  = 2'd2,
    RESOLVE = 2'd3
  } state_e;

  state_e r_state;
  state_e w_next;
  logic   w_ex_hit;
  logic   w_mem_hit;
  logic   w_stalling;
  logic   w_resolving;

  // A destination register hits when it is non-zero and feeds either beq operand.
  function automatic logic f_match(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  assign w_ex_hit  = f_match(ex_rd_i, rs1_addr_i, rs2_addr_i);
  assign w_mem_hit = f_match(mem_rd_i, rs1_addr_i, rs2_addr_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Dropping branch_i in any state aborts back to IDLE with quiet outputs.
  always_comb begin
    w_next      = IDLE;
    w_stalling  = 1'b0;
    w_resolving = 1'b0;
    if (rst_i && branch_i) begin
      case (r_state)
        IDLE: begin
          if (ex_regwrite_i && ex_memread_i && w_ex_hit) begin
            w_next = STALL2;
          end else if (ex_regwrite_i && w_ex_hit) begin
            w_next = STALL1;
          end else if (mem_memread_i && mem_regwrite_i && w_mem_hit) begin
            w_next = STALL1;
          end else begin
            w_resolving = 1'b1;
          end
        end
        STALL2: begin
          w_next     = STALL1;
          w_stalling = 1'b1;
        end
        STALL1: begin
          w_next     = RESOLVE;
          w_stalling = 1'b1;
        end
        RESOLVE: begin
          w_next      = IDLE;
          w_resolving = 1'b1;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  assign stall_o     = w_stalling;
  assign bubble_o    = w_stalling;
  assign pc_src_o    = w_resolving & equal_i;
  assign flush_o     = w_resolving & equal_i;
  assign pc_target_o = (w_resolving & equal_i) ? target_i : 32'd0;

`ifdef BRANCH_HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_nottaken_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating statistics; each counter sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_taken_cnt    <= '0;
      r_nottaken_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_resolving && equal_i && (r_taken_cnt != CNT_MAX)) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
      if (w_resolving && !equal_i && (r_nottaken_cnt != CNT_MAX)) begin
        r_nottaken_cnt <= r_nottaken_cnt + CNT_W'(1);
      end
      if (w_stalling && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign taken_cnt_o    = rst_i ? r_taken_cnt : '0;
  assign nottaken_cnt_o = rst_i ? r_nottaken_cnt : '0;
  assign stall_cnt_o    = rst_i ? r_stall_cnt : '0;
`else
  assign taken_cnt_o    = CNT_W'(0);
  assign nottaken_cnt_o = CNT_W'(0);
  assign stall_cnt_o    = CNT_W'(0);
`endif

endmodule
